// File: rtl/matrix_input_writer_if.sv
// Bus bundle for matrix_input_writer: element stream, allocator handshake,
// BRAM write port and commit channel. master = writer side, slave = environment.
interface matrix_input_writer_if #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 12
);
  logic [ELEMENT_WIDTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;

  logic                     alloc_req;
  logic [3:0]               alloc_m;
  logic [3:0]               alloc_n;
  logic                     alloc_valid;
  logic [3:0]               alloc_slot;
  logic [ADDR_WIDTH-1:0]    alloc_addr;

  logic                     bram_we;
  logic [ADDR_WIDTH-1:0]    bram_addr;
  logic [ELEMENT_WIDTH-1:0] bram_wdata;

  logic                     commit_req;
  logic [3:0]               commit_slot;
  logic [3:0]               commit_m;
  logic [3:0]               commit_n;
  logic [ADDR_WIDTH-1:0]    commit_addr;

  modport master (
    input  in_data, in_valid, alloc_valid, alloc_slot, alloc_addr,
    output in_ready, alloc_req, alloc_m, alloc_n,
           bram_we, bram_addr, bram_wdata,
           commit_req, commit_slot, commit_m, commit_n, commit_addr
  );

  modport slave (
    output in_data, in_valid, alloc_valid, alloc_slot, alloc_addr,
    input  in_ready, alloc_req, alloc_m, alloc_n,
           bram_we, bram_addr, bram_wdata,
           commit_req, commit_slot, commit_m, commit_n, commit_addr
  );
endinterface

// File: rtl/matrix_input_writer.sv
// Matrix entry front end: shape check, slot allocation, BRAM element writes, commit.
// Optional MATRIX_INPUT_WRITER_CLAMP_EN clamps elements to ELEM_MAX and adds clamp_seen.
module matrix_input_writer #(
  parameter int MAX_DIM       = 5,
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 12,
  parameter int ALLOC_TIMEOUT = 4
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
  , parameter int ELEM_MAX    = 9
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cfg_m,
  input  logic [3:0] cfg_n,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [3:0] result_slot,
  output logic       err,
  output logic [1:0] err_code,
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
  output logic       clamp_seen,
`endif
  matrix_input_writer_if.master bus
);

  typedef enum logic [2:0] {IDLE, ALLOC, ALLOC_WAIT, WRITE, COMMIT, FINISH} state_t;

  localparam logic [3:0] DIM_MAX   = 4'(MAX_DIM);
  localparam logic [7:0] WAIT_LAST = 8'(ALLOC_TIMEOUT - 1);

  state_t                   state, next_state;
  logic [3:0]               m_q, n_q, slot_q;
  logic [7:0]               total_q, idx_q, wait_cnt_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic                     err_q;
  logic [1:0]               err_code_q;
  logic [3:0]               result_slot_q;
  logic                     bram_we_q;
  logic [ADDR_WIDTH-1:0]    bram_addr_q;
  logic [ELEMENT_WIDTH-1:0] bram_wdata_q;
  logic                     dims_ok;
  logic                     last_beat;
  logic [ELEMENT_WIDTH-1:0] wdata_in;

  assign dims_ok = (cfg_m != 4'd0) && (cfg_m <= DIM_MAX) &&
                   (cfg_n != 4'd0) && (cfg_n <= DIM_MAX);
  assign last_beat = bus.in_valid && (idx_q == total_q - 8'd1);

`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
  localparam logic [ELEMENT_WIDTH-1:0] CEIL = ELEMENT_WIDTH'(ELEM_MAX);
  logic clamp_hit;
  assign clamp_hit = bus.in_data > CEIL;
  assign wdata_in  = clamp_hit ? CEIL : bus.in_data;
`else
  assign wdata_in  = bus.in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (start && dims_ok) next_state = ALLOC;
      ALLOC:      next_state = abort ? IDLE : ALLOC_WAIT;
      ALLOC_WAIT: begin
        if (abort)                       next_state = IDLE;
        else if (bus.alloc_valid)        next_state = WRITE;
        else if (wait_cnt_q == WAIT_LAST) next_state = IDLE;
      end
      WRITE: begin
        if (abort)          next_state = IDLE;
        else if (last_beat) next_state = COMMIT;
      end
      COMMIT:     next_state = FINISH;
      FINISH:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state == WRITE);
    bus.alloc_req   = (state == ALLOC);
    bus.commit_req  = (state == COMMIT);
    busy            = (state != IDLE);
    done            = (state == FINISH);
    bus.alloc_m     = m_q;
    bus.alloc_n     = n_q;
    bus.commit_slot = slot_q;
    bus.commit_m    = m_q;
    bus.commit_n    = n_q;
    bus.commit_addr = base_q;
    bus.bram_we     = bram_we_q;
    bus.bram_addr   = bram_addr_q;
    bus.bram_wdata  = bram_wdata_q;
    err             = err_q;
    err_code        = err_code_q;
    result_slot     = result_slot_q;
  end

  // err and bram_we are single-cycle pulses; everything else holds until rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q           <= '0;
      n_q           <= '0;
      slot_q        <= '0;
      total_q       <= '0;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      base_q        <= '0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
      result_slot_q <= 4'hF;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_wdata_q  <= '0;
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
      clamp_seen    <= 1'b0;
`endif
    end else begin
      err_q     <= 1'b0;
      bram_we_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (dims_ok) begin
              m_q        <= cfg_m;
              n_q        <= cfg_n;
              total_q    <= {4'd0, cfg_m} * {4'd0, cfg_n};
              err_code_q <= 2'd0;
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
              clamp_seen <= 1'b0;
`endif
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
            end
          end
        end
        ALLOC: begin
          wait_cnt_q <= '0;
          if (abort) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
          end
        end
        ALLOC_WAIT: begin
          if (abort) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
          end else if (bus.alloc_valid) begin
            slot_q <= bus.alloc_slot;
            base_q <= bus.alloc_addr;
            idx_q  <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd2;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        WRITE: begin
          // A beat coinciding with abort is still written before giving up.
          if (bus.in_valid) begin
            bram_we_q    <= 1'b1;
            bram_addr_q  <= base_q + ADDR_WIDTH'(idx_q);
            bram_wdata_q <= wdata_in;
            idx_q        <= idx_q + 8'd1;
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
            if (clamp_hit) clamp_seen <= 1'b1;
`endif
          end
          if (abort) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
          end
        end
        COMMIT: begin
          result_slot_q <= slot_q;
          err_code_q    <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_input_writer.sv
// Self-checking bench for matrix_input_writer: table of entries plus hand-written
// corner sequences; BRAM writes are checked against a scoreboard queue.
module tb_matrix_input_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_m = '0;
  logic [3:0] cfg_n = '0;
  logic       busy, done, err;
  logic [3:0] result_slot;
  logic [1:0] err_code;
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
  logic       clamp_seen;
`endif

  matrix_input_writer_if #(.ELEMENT_WIDTH(8), .ADDR_WIDTH(12)) bus ();

  matrix_input_writer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .abort(abort),
    .busy(busy), .done(done), .result_slot(result_slot), .err(err), .err_code(err_code),
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
    .clamp_seen(clamp_seen),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m; int n; bit grant; int slot; int addr; bit gap;
    int abort_after; bit abort_with_beat; int data0; int exp_code; bit exp_done;
  } vec_t;

  vec_t        vecs[11];
  logic [19:0] wq[$];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0;
  int          n_writes, n_alloc, n_commit, n_done, n_err, n_both = 0;
  int          commit_cyc, done_cyc;
  bit          busy_seen;
  logic [3:0]  c_slot, c_m, c_n, a_m, a_n, done_slot;
  logic [11:0] c_addr;
  logic [1:0]  code_at_err;
  bit          grant_en = 1'b0;
  logic [3:0]  grant_slot = '0;
  logic [11:0] grant_addr = '0;
  logic [3:0]  exp_result_slot = 4'hF;
  bit          exp_clamp = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic reset_counters();
    n_writes = 0; n_alloc = 0; n_commit = 0; n_done = 0; n_err = 0;
    commit_cyc = -100; done_cyc = -200; busy_seen = 0;
  endtask

  // Allocator model: grant arrives the cycle after alloc_req is seen.
  initial begin
    bit pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      bus.alloc_valid = pending;
      bus.alloc_slot  = grant_slot;
      bus.alloc_addr  = grant_addr;
      pending = bus.alloc_req && grant_en;
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.bram_we) begin
        n_writes++;
        if (wq.size() == 0) check_output("bram_unexpected_write", 32'(wq.size()), 1);
        else begin
          e = wq.pop_front();
          check_output("bram_addr", bus.bram_addr, e[19:8]);
          check_output("bram_wdata", bus.bram_wdata, e[7:0]);
        end
      end
      if (bus.alloc_req) begin n_alloc++; a_m = bus.alloc_m; a_n = bus.alloc_n; end
      if (bus.commit_req) begin
        n_commit++; commit_cyc = cyc;
        c_slot = bus.commit_slot; c_m = bus.commit_m; c_n = bus.commit_n; c_addr = bus.commit_addr;
      end
      if (done) begin n_done++; done_cyc = cyc; done_slot = result_slot; end
      if (err) begin n_err++; code_at_err = err_code; end
      if (done && err) n_both++;
      if (busy) busy_seen = 1;
    end
  end

  task automatic push_beat(input vec_t v, input int beat);
    logic [7:0] val, expd;
    val  = 8'(v.data0 + beat);
    expd = val;
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
    if (val > 8'd9) begin expd = 8'd9; exp_clamp = 1'b1; end
`endif
    bus.in_data = val;
    wq.push_back({12'(v.addr + beat), expd});
  endtask

  task automatic apply_stimulus(input vec_t v);
    int total, beat, budget, exp_writes;
    bit finished, seen_ready, ready_drop, legal, valid;
    total = v.m * v.n;
    legal = (v.exp_code != 1);
    reset_counters();
    grant_en = v.grant; grant_slot = 4'(v.slot); grant_addr = 12'(v.addr);
    if (legal) exp_clamp = 1'b0;
    start = 1'b1; cfg_m = 4'(v.m); cfg_n = 4'(v.n);
    @(negedge clk);
    start = 1'b0;
    beat = 0; finished = 0; seen_ready = 0; ready_drop = 0;
    if (legal && v.grant) begin
      budget = 0;
      while (!finished && budget < 80) begin
        budget++;
        if (bus.in_ready) seen_ready = 1;
        else if (seen_ready) ready_drop = 1;
        if (v.abort_after >= 0 && beat == v.abort_after && bus.in_ready) begin
          abort = 1'b1;
          bus.in_valid = v.abort_with_beat;
          if (v.abort_with_beat) begin push_beat(v, beat); beat++; end
          finished = 1;
        end else begin
          valid = v.gap ? budget[0] : 1'b1;
          bus.in_valid = valid;
          bus.in_data  = 8'(v.data0 + beat);
          if (valid && bus.in_ready) begin
            push_beat(v, beat);
            beat++;
            if (beat == total) finished = 1;
          end
        end
        @(negedge clk);
      end
      abort = 1'b0;
      bus.in_valid = 1'b0;
      if (!finished) check_output("feed_timeout", beat, total);
      check_output("in_ready_after_last", bus.in_ready, 0);
      if (v.abort_after < 0) check_output("in_ready_held", ready_drop, 0);
    end
    repeat (12) @(negedge clk);
    exp_writes = v.exp_done ? total : (v.abort_after >= 0 ? v.abort_after + v.abort_with_beat : 0);
    if (v.exp_done) exp_result_slot = 4'(v.slot);
    check_output("err_code", err_code, v.exp_code);
    check_output("err_count", n_err, (v.exp_code != 0) ? 1 : 0);
    if (v.exp_code != 0) check_output("err_code_at_pulse", code_at_err, v.exp_code);
    check_output("done_count", n_done, v.exp_done);
    check_output("commit_count", n_commit, v.exp_done);
    check_output("alloc_count", n_alloc, legal ? 1 : 0);
    check_output("busy_seen", busy_seen, legal);
    check_output("write_count", n_writes, exp_writes);
    check_output("scoreboard_empty", wq.size(), 0);
    check_output("result_slot", result_slot, exp_result_slot);
    if (legal) begin
      check_output("alloc_m", a_m, v.m);
      check_output("alloc_n", a_n, v.n);
    end
    if (v.exp_done) begin
      check_output("commit_slot", c_slot, v.slot);
      check_output("commit_m", c_m, v.m);
      check_output("commit_n", c_n, v.n);
      check_output("commit_addr", c_addr, v.addr);
      check_output("done_after_commit", done_cyc - commit_cyc, 1);
      check_output("done_result_slot", done_slot, v.slot);
    end
`ifdef MATRIX_INPUT_WRITER_CLAMP_EN
    check_output("clamp_seen", clamp_seen, exp_clamp);
`endif
    wq.delete();
  endtask

  initial begin
    int b;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.alloc_valid = 1'b0; bus.alloc_slot = '0; bus.alloc_addr = '0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_err_code", err_code, 0);
    check_output("rst_result_slot", result_slot, 4'hF);
    check_output("rst_in_ready", bus.in_ready, 0);
    check_output("rst_alloc_req", bus.alloc_req, 0);
    check_output("rst_bram_we", bus.bram_we, 0);
    check_output("rst_commit_req", bus.commit_req, 0);
    rst = 1'b0;
    @(negedge clk);

    //           m  n  gr slot addr    gap abA wb data0 code done
    vecs[0]  = '{2, 3, 1, 2, 'h010,  0, -1, 0, 1,    0, 1};
    vecs[1]  = '{2, 3, 1, 2, 'h010,  1, -1, 0, 1,    0, 1};
    vecs[2]  = '{0, 3, 1, 2, 'h010,  0, -1, 0, 1,    1, 0};
    vecs[3]  = '{6, 3, 1, 2, 'h010,  0, -1, 0, 1,    1, 0};
    vecs[4]  = '{3, 0, 1, 2, 'h010,  0, -1, 0, 1,    1, 0};
    vecs[5]  = '{3, 3, 0, 2, 'h010,  0, -1, 0, 1,    2, 0};
    vecs[6]  = '{4, 4, 1, 5, 'h100,  0,  5, 0, 'h20, 3, 0};
    vecs[7]  = '{1, 1, 1, 7, 'h200,  0, -1, 0, 4,    0, 1};
    vecs[8]  = '{5, 5, 1, 1, 'hFFE,  0, -1, 0, 'hF0, 0, 1};
    vecs[9]  = '{2, 2, 1, 3, 'h040,  0,  3, 1, 7,    3, 0};
    vecs[10] = '{1, 2, 1, 4, 'h020,  0, -1, 0, 12,   0, 1};
    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);

    // Abort together with the grant: abort must win.
    reset_counters();
    grant_en = 1'b1; grant_slot = 4'd6; grant_addr = 12'h300;
    start = 1'b1; cfg_m = 4'd2; cfg_n = 4'd2;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (!bus.alloc_req && b < 10) begin @(negedge clk); b++; end
    if (b >= 10) check_output("alloc_req_timeout", bus.alloc_req, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (8) @(negedge clk);
    check_output("abort_grant_err_code", err_code, 3);
    check_output("abort_grant_err_count", n_err, 1);
    check_output("abort_grant_commit", n_commit, 0);
    check_output("abort_grant_writes", n_writes, 0);
    check_output("abort_grant_done", n_done, 0);

    // Reset in the middle of ALLOC_WAIT: silent abandonment.
    reset_counters();
    grant_en = 1'b0;
    start = 1'b1; cfg_m = 4'd3; cfg_n = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_result_slot = 4'hF;
    check_output("midrst_err_count", n_err, 0);
    check_output("midrst_commit", n_commit, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_result_slot", result_slot, exp_result_slot);
    check_output("midrst_err_code", err_code, 0);

    check_output("done_err_overlap", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
